// File: rtl/serial_exec_ctrl.sv
// rtl/serial_exec_ctrl.sv - sequencing FSM for the bit-serial ALU datapath
module serial_exec_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = $clog2(WIDTH),
  parameter bit WRITEBACK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inst_valid,
  input  logic [3:0]       opcode,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             reg_shift_en,
  output logic             imm_shift_en,
  output logic             acc_shift_en,
  output logic             acc_write_en,
  output logic             reg_write_en,
  output logic [1:0]       alu_op,
  output logic             b_invert,
  output logic             carry_load,
  output logic             carry_init_val,
  output logic             carry_en,
  output logic [CNT_W-1:0] bit_idx
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_WB, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0110, 4'b0101, 4'b0100,
      4'b1000, 4'b1001, 4'b1100, 4'b1011, 4'b1010: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 4'b0000;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start && inst_valid) begin
            op_d = opcode;
            if (op_legal(opcode)) state_d = S_LOAD;
            else                  illegal_d = 1'b1;
          end
        end
        S_LOAD: begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_WB;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WB:    state_d = S_DONE;
        S_DONE: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Operation class decoded from the latched opcode only, never the live input.
  logic       is_itype, is_rtype, is_sub;
  logic [1:0] op_alu;

  always_comb begin
    is_itype = 1'b0;
    is_rtype = 1'b0;
    op_alu   = 2'b00;
    case (op_q)
      4'b0000, 4'b0001: is_rtype = 1'b1;
      4'b0110: begin is_rtype = 1'b1; op_alu = 2'b01; end
      4'b0101: begin is_rtype = 1'b1; op_alu = 2'b10; end
      4'b0100: begin is_rtype = 1'b1; op_alu = 2'b11; end
      4'b1000, 4'b1001: is_itype = 1'b1;
      4'b1100: begin is_itype = 1'b1; op_alu = 2'b01; end
      4'b1011: begin is_itype = 1'b1; op_alu = 2'b10; end
      4'b1010: begin is_itype = 1'b1; op_alu = 2'b11; end
      default: ;
    endcase
    is_sub = (op_q == 4'b0001) || (op_q == 4'b1001);
  end

  always_comb begin
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    illegal        = illegal_q;
    reg_shift_en   = 1'b0;
    imm_shift_en   = 1'b0;
    acc_shift_en   = 1'b0;
    acc_write_en   = 1'b0;
    reg_write_en   = 1'b0;
    alu_op         = 2'b00;
    b_invert       = 1'b0;
    carry_load     = 1'b0;
    carry_init_val = 1'b0;
    carry_en       = 1'b0;
    bit_idx        = cnt_q;
    case (state_q)
      S_LOAD: begin
        carry_load     = 1'b1;
        carry_init_val = is_sub;
      end
      S_EXEC: begin
        reg_shift_en = is_rtype;
        imm_shift_en = is_itype;
        acc_shift_en = 1'b1;
        acc_write_en = 1'b1;
        alu_op       = op_alu;
        b_invert     = is_sub;
        carry_en     = (op_alu == 2'b00);
      end
      S_WB:    reg_write_en = WRITEBACK;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_exec_ctrl.sv
// tb/tb_serial_exec_ctrl.sv - scoreboard bench for serial_exec_ctrl (WIDTH 8/WB and WIDTH 16/no WB)
module tb_serial_exec_ctrl;

  localparam int PH_IDLE = 0, PH_ILL = 1, PH_LOAD = 2, PH_EXEC = 3, PH_WB = 4, PH_DONE = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, iv8, fl8, start16, iv16, fl16;
  logic [3:0] op8, op16;

  logic       busy8, done8, ill8, rs8, is8, as8, aw8, rw8, bi8, cl8, civ8, ce8;
  logic [1:0] alu8;
  logic [2:0] idx8;
  logic       busy16, done16, ill16, rs16, is16, as16, aw16, rw16, bi16, cl16, civ16, ce16;
  logic [1:0] alu16;
  logic [3:0] idx16;

  serial_exec_ctrl #(.WIDTH(8), .WRITEBACK(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .inst_valid(iv8), .opcode(op8), .flush(fl8),
    .busy(busy8), .done(done8), .illegal(ill8), .reg_shift_en(rs8), .imm_shift_en(is8),
    .acc_shift_en(as8), .acc_write_en(aw8), .reg_write_en(rw8), .alu_op(alu8), .b_invert(bi8),
    .carry_load(cl8), .carry_init_val(civ8), .carry_en(ce8), .bit_idx(idx8)
  );

  serial_exec_ctrl #(.WIDTH(16), .WRITEBACK(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .inst_valid(iv16), .opcode(op16), .flush(fl16),
    .busy(busy16), .done(done16), .illegal(ill16), .reg_shift_en(rs16), .imm_shift_en(is16),
    .acc_shift_en(as16), .acc_write_en(aw16), .reg_write_en(rw16), .alu_op(alu16), .b_invert(bi16),
    .carry_load(cl16), .carry_init_val(civ16), .carry_en(ce16), .bit_idx(idx16)
  );

  // {busy,done,illegal,reg_sh,imm_sh,acc_sh,acc_wr,reg_wr,alu_op[1:0],b_inv,c_load,c_init,c_en,bit_idx[4:0]}
  logic [18:0] obs8, obs16;
  assign obs8  = {busy8, done8, ill8, rs8, is8, as8, aw8, rw8, alu8, bi8, cl8, civ8, ce8, 2'b00, idx8};
  assign obs16 = {busy16, done16, ill16, rs16, is16, as16, aw16, rw16, alu16, bi16, cl16, civ16, ce16, 1'b0, idx16};

  int total = 0;
  int bad   = 0;

  logic [18:0] q8[$];
  logic [18:0] q16[$];
  string       t8[$];
  string       t16[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h6, 4'h5, 4'h4, 4'h8, 4'h9, 4'hC, 4'hB, 4'hA};
  endfunction

  function automatic logic [18:0] ev(input int ph, input logic [3:0] op, input int idx, input bit wb);
    logic r, i, sub;
    logic [1:0] a;
    logic [18:0] v;
    r = 1'b0; i = 1'b0; sub = 1'b0; a = 2'b00; v = '0;
    case (op)
      4'h0: r = 1'b1;
      4'h1: begin r = 1'b1; sub = 1'b1; end
      4'h6: begin r = 1'b1; a = 2'b01; end
      4'h5: begin r = 1'b1; a = 2'b10; end
      4'h4: begin r = 1'b1; a = 2'b11; end
      4'h8: i = 1'b1;
      4'h9: begin i = 1'b1; sub = 1'b1; end
      4'hC: begin i = 1'b1; a = 2'b01; end
      4'hB: begin i = 1'b1; a = 2'b10; end
      4'hA: begin i = 1'b1; a = 2'b11; end
      default: ;
    endcase
    case (ph)
      PH_ILL:  v[16] = 1'b1;
      PH_LOAD: begin v[18] = 1'b1; v[7] = 1'b1; v[6] = sub; end
      PH_EXEC: begin
        v[18] = 1'b1; v[15] = r; v[14] = i; v[13] = 1'b1; v[12] = 1'b1;
        v[10:9] = a; v[8] = sub; v[5] = (a == 2'b00); v[4:0] = idx[4:0];
      end
      PH_WB:   begin v[18] = 1'b1; v[11] = wb; end
      PH_DONE: begin v[18] = 1'b1; v[17] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (q8.size() != 0)  chk(t8.pop_front(), {13'd0, obs8}, {13'd0, q8.pop_front()});
    if (q16.size() != 0) chk(t16.pop_front(), {13'd0, obs16}, {13'd0, q16.pop_front()});
  end

  // Inputs change just after the falling edge; e is the output expected after the next rising edge.
  task automatic step(input int sel, input logic st, input logic iv, input logic fl,
                      input logic [3:0] op, input logic [18:0] e, input string tag, input bit push);
    @(negedge clk);
    #1;
    if (sel == 0) begin
      start8 = st; iv8 = iv; fl8 = fl; op8 = op;
      if (push) begin q8.push_back(e); t8.push_back(tag); end
    end else begin
      start16 = st; iv16 = iv; fl16 = fl; op16 = op;
      if (push) begin q16.push_back(e); t16.push_back(tag); end
    end
  endtask

  task automatic run(input int sel, input logic [3:0] op, input int rs_i, input int fl_i, input int rst_i);
    int w;
    bit wb;
    logic [3:0] oth;
    w   = (sel != 0) ? 16 : 8;
    wb  = (sel == 0);
    oth = ~op;
    if (!legal(op)) begin
      step(sel, 1'b1, 1'b1, 1'b0, op, ev(PH_ILL, op, 0, wb), $sformatf("ill_op%h", op), 1'b1);
      step(sel, 1'b0, 1'b1, 1'b0, oth, ev(PH_IDLE, op, 0, wb), $sformatf("ill_idle_op%h", op), 1'b1);
      return;
    end
    step(sel, 1'b1, 1'b1, 1'b0, op, ev(PH_LOAD, op, 0, wb), $sformatf("load_op%h", op), 1'b1);
    for (int i = 0; i < w; i++) begin
      if (rst_i >= 0 && i == rst_i + 1) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0; start8 = 1'b0; fl8 = 1'b0; start16 = 1'b0; fl16 = 1'b0;
        #1;
        chk("rst_async", {13'd0, obs8}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (fl_i >= 0 && i == fl_i + 1) begin
        step(sel, 1'b0, 1'b1, 1'b1, oth, ev(PH_IDLE, op, 0, wb), $sformatf("flush_op%h", op), 1'b1);
        step(sel, 1'b0, 1'b1, 1'b0, oth, ev(PH_IDLE, op, 0, wb), $sformatf("post_flush_op%h", op), 1'b1);
        return;
      end
      step(sel, (rs_i >= 0 && i == rs_i + 1), 1'b1, 1'b0, oth, ev(PH_EXEC, op, i, wb),
           $sformatf("exec%0d_op%h", i, op), 1'b1);
    end
    step(sel, 1'b0, 1'b1, 1'b0, oth, ev(PH_WB, op, 0, wb), $sformatf("wb_op%h", op), 1'b1);
    step(sel, 1'b0, 1'b1, 1'b0, oth, ev(PH_DONE, op, 0, wb), $sformatf("done_op%h", op), 1'b1);
    step(sel, 1'b0, 1'b1, 1'b0, oth, ev(PH_IDLE, op, 0, wb), $sformatf("idle_op%h", op), 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; iv8 = 1'b0; fl8 = 1'b0; op8 = 4'h0;
    start16 = 1'b0; iv16 = 1'b0; fl16 = 1'b0; op16 = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset8", {13'd0, obs8}, 32'd0);
    chk("reset16", {13'd0, obs16}, 32'd0);
    #1;
    rst_n = 1'b1;

    run(0, 4'h0, -1, -1, -1);
    run(0, 4'h9, -1, -1, -1);
    run(0, 4'h7, -1, -1, -1);
    run(0, 4'hB, 3, 5, -1);
    run(0, 4'h0, -1, -1, 4);
    run(0, 4'h0, -1, -1, -1);
    run(1, 4'h6, -1, -1, -1);

    step(0, 1'b1, 1'b0, 1'b0, 4'h0, ev(PH_IDLE, 4'h0, 0, 1'b1), "no_inst_valid", 1'b1);
    step(0, 1'b1, 1'b1, 1'b1, 4'h0, ev(PH_IDLE, 4'h0, 0, 1'b1), "flush_beats_start", 1'b1);
    step(0, 1'b0, 1'b1, 1'b0, 4'h0, ev(PH_IDLE, 4'h0, 0, 1'b1), "idle_after_prio", 1'b1);

    for (int op = 0; op < 16; op++) run(0, 4'(op), -1, -1, -1);
    run(1, 4'h1, -1, -1, -1);

    repeat (3) step(0, 1'b0, 1'b0, 1'b0, 4'h0, '0, "drain", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
